// File: rtl/matmul_pkg.sv
// Shared types and defaults for the 2x2 byte matmul operand loader.
package matmul_pkg;

  localparam int unsigned ELEM_W_DEF = 8;
  localparam int unsigned DIM_DEF    = 2;
  localparam int unsigned WORD_W_DEF = ELEM_W_DEF * DIM_DEF * DIM_DEF;

  typedef logic [ELEM_W_DEF-1:0] elem_t;
  typedef logic [WORD_W_DEF-1:0] mword_t;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    HOLD   = 2'd2
  } loader_state_e;

endpackage

// File: rtl/matmul_elem_shreg.sv
// Shift-in register: each enabled cycle pushes one element in at the LSB end,
// so the first element received ends up in the most-significant slot.
module matmul_elem_shreg
  import matmul_pkg::*;
#(
  parameter int unsigned ELEM_W   = ELEM_W_DEF,
  parameter int unsigned NUM_ELEM = DIM_DEF * DIM_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         load_en_i,
  input  logic [ELEM_W-1:0]            din_i,
  output logic [ELEM_W*NUM_ELEM-1:0]   q_o
);

  localparam int unsigned W = ELEM_W * NUM_ELEM;

  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load_en_i) q_d = {q_q[W-ELEM_W-1:0], din_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/matmul_operand_loader.sv
// Packs a serial element stream into operand words A and B for the matmul.
// Define MATMUL_LOADER_DBUF_EN for a second output stage so loading overlaps draining.
module matmul_operand_loader
  import matmul_pkg::*;
#(
  parameter int unsigned ELEM_W = ELEM_W_DEF,
  parameter int unsigned DIM    = DIM_DEF,
  localparam int unsigned WORD_W = ELEM_W * DIM * DIM
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [ELEM_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [WORD_W-1:0] A,
  output logic [WORD_W-1:0] B,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

  localparam int unsigned NumElem = DIM * DIM;
  localparam int unsigned CntW    = (NumElem > 1) ? $clog2(NumElem) : 1;

  loader_state_e   state_q, state_d, b_done_state;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            rdy_en_q;
  logic            in_fire, out_fire, last_elem, shift_a, shift_b;
  logic            hold_exit, hold_take;
  logic [WORD_W-1:0] a_word, b_word;

  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign last_elem = (cnt_q == CntW'(NumElem - 1));
  // An element accepted while in HOLD (only possible with the output stage) starts a new A.
  assign shift_a   = in_fire && !flush && (state_q != LOAD_B);
  assign shift_b   = in_fire && !flush && (state_q == LOAD_B);

  matmul_elem_shreg #(
    .ELEM_W   (ELEM_W),
    .NUM_ELEM (NumElem)
  ) u_shreg_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_en_i (shift_a),
    .din_i     (in_data),
    .q_o       (a_word)
  );

  matmul_elem_shreg #(
    .ELEM_W   (ELEM_W),
    .NUM_ELEM (NumElem)
  ) u_shreg_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_en_i (shift_b),
    .din_i     (in_data),
    .q_o       (b_word)
  );

`ifdef MATMUL_LOADER_DBUF_EN
  logic [WORD_W-1:0] a_out_q, a_out_d, b_out_q, b_out_d;
  logic              ov_q, ov_d, stage_free;

  assign stage_free   = !ov_q || out_ready;
  assign b_done_state = stage_free ? LOAD_A : HOLD;
  assign hold_exit    = stage_free;
  assign hold_take    = stage_free;

  always_comb begin
    a_out_d = a_out_q;
    b_out_d = b_out_q;
    ov_d    = ov_q;
    if (out_fire) ov_d = 1'b0;
    if (flush) begin
      ov_d = 1'b0;
    end else if (shift_b && last_elem && stage_free) begin
      // Bypass the B register so the frame lands in the stage on its last element.
      a_out_d = a_word;
      b_out_d = {b_word[WORD_W-ELEM_W-1:0], in_data};
      ov_d    = 1'b1;
    end else if ((state_q == HOLD) && stage_free) begin
      a_out_d = a_word;
      b_out_d = b_word;
      ov_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_out_q <= '0;
      b_out_q <= '0;
      ov_q    <= 1'b0;
    end else begin
      a_out_q <= a_out_d;
      b_out_q <= b_out_d;
      ov_q    <= ov_d;
    end
  end

  assign out_valid = ov_q;
  assign A         = a_out_q;
  assign B         = b_out_q;
`else
  assign b_done_state = HOLD;
  assign hold_exit    = out_fire;
  assign hold_take    = 1'b0;
  assign out_valid    = (state_q == HOLD);
  assign A            = a_word;
  assign B            = b_word;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= LOAD_A;
      cnt_q    <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rdy_en_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (in_fire) cnt_d = last_elem ? '0 : cnt_q + CntW'(1);
    case (state_q)
      LOAD_A:  if (in_fire && last_elem) state_d = LOAD_B;
      LOAD_B:  if (in_fire && last_elem) state_d = b_done_state;
      HOLD:    if (hold_exit) state_d = LOAD_A;
      default: state_d = LOAD_A;
    endcase
    if (flush) begin
      state_d = LOAD_A;
      cnt_d   = '0;
    end
  end

  always_comb begin
    in_ready = rdy_en_q && ((state_q != HOLD) || hold_take);
    busy     = (cnt_q != '0) || (state_q == LOAD_B);
  end

endmodule
